// File: rtl/mux2_sel_arbiter.sv
// Round-robin, burst-bounded arbiter driving a registered 2:1 mux select and output stage.
// Latency: request -> grant 1 cycle, grant -> y/y_valid 1 cycle (request -> valid data 2 cycles).
// Backpressure: none; a requester holds req until served, bursts are capped at MAX_BURST under contention.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   req0, req1      requests from requester 0 / 1
//   i0, i1          data from requester 0 / 1 (DW bits)
//   sel             registered mux select (0 -> i0, 1 -> i1), holds while idle
//   gnt0, gnt1      grants decoded from the state register, mutually exclusive
//   y, y_valid      registered mux output and its valid flag
module mux2_sel_arbiter #(
  parameter int DW        = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] i0,
  input  logic [DW-1:0] i1,
  output logic          sel,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] y,
  output logic          y_valid
);

  localparam int            CW      = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sel_q, sel_d;
  logic [DW-1:0]   y_q;
  logic            y_valid_q;

  // State register (with last-served and burst counter)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;   // first tie after reset goes to requester 0
      cnt_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 && req1)  state_d = last_q ? G0 : G1;
        else if (req0)     state_d = G0;
        else if (req1)     state_d = G1;
      end
      G0: begin
        // Keep the grant unless the burst cap is hit while the other side waits.
        if (req0 && (!req1 || cnt_q < CNT_MAX)) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end else if (req1) begin
          state_d = G1;
          cnt_d   = '0;
          last_d  = 1'b0;
        end else begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      G1: begin
        if (req1 && (!req0 || cnt_q < CNT_MAX)) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end else if (req0) begin
          state_d = G0;
          cnt_d   = '0;
          last_d  = 1'b1;
        end else begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: select follows the upcoming grant state and holds while idle,
  // so it always matches the grant registered alongside it.
  always_comb begin
    sel_d = sel_q;
    if (state_d == G0)      sel_d = 1'b0;
    else if (state_d == G1) sel_d = 1'b1;
    gnt0 = (state_q == G0);
    gnt1 = (state_q == G1);
  end

  // Data stage: driven from the registered state only, never from raw requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      case (state_q)
        G0: begin
          y_q       <= i0;
          y_valid_q <= 1'b1;
        end
        G1: begin
          y_q       <= i1;
          y_valid_q <= 1'b1;
        end
        default: y_valid_q <= 1'b0;
      endcase
    end
  end

  assign sel     = sel_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule
